// File: rtl/seg_timer_scan.sv
// -----------------------------------------------------------------------------
// seg_timer_scan
//   Fully synchronous mm:ss-style BCD up/down timer with run/pause/clear/preload,
//   an expiry flag and a multiplexed active-low 7-segment display driver.
//
// Parameters
//   CLK_HZ     : CLK cycles per count step (>= 2)
//   SCAN_DIV   : CLK cycles per digit-strobe step (>= 1)
//   NUM_DIGITS : displayed digits, even, 2..8 (even index mod 10, odd mod 6)
//
// Ports
//   CLK        in   system clock
//   RST        in   synchronous reset, active-high
//   run        in   level, 1 = count, 0 = pause
//   clear      in   pulse, zero all digits and return to IDLE
//   mode_down  in   0 = up, 1 = down; latched on IDLE -> RUN
//   load       in   pulse, preload from load_val (IDLE only, digits clamped)
//   load_val   in   BCD preload, digit 0 in the LSBs
//   SEG        out  segments {a,b,c,d,e,f,g}, active-low
//   COM        out  one-hot active-low digit strobes
//   bcd        out  current count
//   running    out  high in RUN
//   expired    out  high in EXPIRED
//   wrap       out  one-cycle pulse on count-up rollover
//
// Optional feature
//   SEG_TIMER_LEADING_BLANK_EN : blank leading zero digits above index 1.
// -----------------------------------------------------------------------------
module seg_timer_scan #(
  parameter int CLK_HZ     = 50000000,
  parameter int SCAN_DIV   = 2500,
  parameter int NUM_DIGITS = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      run,
  input  logic                      clear,
  input  logic                      mode_down,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   load_val,
  output logic [6:0]                SEG,
  output logic [NUM_DIGITS-1:0]     COM,
  output logic [4*NUM_DIGITS-1:0]   bcd,
  output logic                      running,
  output logic                      expired,
  output logic                      wrap
);

  localparam int BW     = 4 * NUM_DIGITS;
  localparam int SEC_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = $clog2(NUM_DIGITS);

  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(CLK_HZ - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_EXPIRED} state_t;

  // Seconds digits count mod 10, tens-of-seconds (and minutes-tens) mod 6.
  function automatic logic [3:0] digit_max(input int i);
    return (i % 2 == 0) ? 4'd9 : 4'd5;
  endfunction

  function automatic logic [BW-1:0] clamp_load(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (v[4*i +: 4] > digit_max(i)) r[4*i +: 4] = digit_max(i);
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [SEC_W-1:0]    sec_cnt;
  logic                dir_down;
  logic                step;
  logic [BW-1:0]       bcd_step;
  logic                ripple;
  logic                hits_zero;

  // Ripple carry (up) or borrow (down) through all digits. ripple is still
  // set after the last digit when every digit rolled: a wrap when counting
  // up, or an underflow from all-zero when counting down.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned, which would infer a latch.
    bcd_step = bcd;
    ripple   = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (ripple) begin
        if (!dir_down) begin
          if (bcd[4*i +: 4] >= digit_max(i)) begin
            bcd_step[4*i +: 4] = 4'd0;
          end else begin
            bcd_step[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
            ripple             = 1'b0;
          end
        end else begin
          if (bcd[4*i +: 4] == 4'd0) begin
            bcd_step[4*i +: 4] = digit_max(i);
          end else begin
            bcd_step[4*i +: 4] = bcd[4*i +: 4] - 4'd1;
            ripple             = 1'b0;
          end
        end
      end
    end
  end

  // A down step expires either by reaching zero or by starting from zero.
  assign hits_zero = dir_down && (ripple || (bcd_step == '0));

  always_comb begin
    state_d = state_q;
    step    = 1'b0;
    case (state_q)
      S_IDLE:    if (run) state_d = S_RUN;
      S_RUN: begin
        if (!run) begin
          state_d = S_PAUSE;
        end else if (sec_cnt == SEC_LAST) begin
          step = 1'b1;
          if (hits_zero) state_d = S_EXPIRED;
        end
      end
      S_PAUSE:   if (run) state_d = S_RUN;
      S_EXPIRED: state_d = S_EXPIRED;
      default:   state_d = S_IDLE;
    endcase
    // clear outranks everything but reset, including a coincident step.
    if (clear) begin
      state_d = S_IDLE;
      step    = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bcd      <= '0;
      sec_cnt  <= '0;
      dir_down <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clear) begin
        bcd     <= '0;
        sec_cnt <= '0;
      end else if (state_q == S_IDLE) begin
        if (load) bcd <= clamp_load(load_val);
        if (run) begin
          dir_down <= mode_down;
          sec_cnt  <= '0;
        end
      end else if (step) begin
        sec_cnt <= '0;
        bcd     <= hits_zero ? '0 : bcd_step;
        wrap    <= !dir_down && ripple;
      end else if (state_q == S_RUN && run) begin
        // The prescaler is left untouched in PAUSE so a partial second survives.
        sec_cnt <= sec_cnt + 1'b1;
      end
    end
  end

  assign running = (state_q == S_RUN);
  assign expired = (state_q == S_EXPIRED);

  // ---------------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------------
  logic [SCAN_W-1:0]     scan_cnt;
  logic                  scan_tick;
  logic [IDX_W-1:0]      scan_idx, idx_nxt;
  logic [NUM_DIGITS-1:0] blank;
  logic [3:0]            digit_sel;
  logic                  blank_sel;

  assign scan_tick = (scan_cnt == SCAN_LAST);

  always_comb begin
    idx_nxt = scan_idx;
    if (scan_tick) idx_nxt = (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
  end

`ifdef SEG_TIMER_LEADING_BLANK_EN
  // Walk down from the top digit; blanking stops at the first non-zero digit.
  always_comb begin
    logic zero_above;
    blank      = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 2; i--) begin
      zero_above = zero_above && (bcd[4*i +: 4] == 4'd0);
      blank[i]   = zero_above;
    end
  end
`else
  assign blank = '0;
`endif

  // SEG is decoded for the digit COM will select next cycle, keeping them aligned.
  always_comb begin
    digit_sel = 4'd0;
    blank_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_nxt == IDX_W'(i)) begin
        digit_sel = bcd[4*i +: 4];
        blank_sel = blank[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      COM      <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
      SEG      <= 7'b0000001;
    end else begin
      scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;
      scan_idx <= idx_nxt;
      if (scan_tick) COM <= {COM[NUM_DIGITS-2:0], COM[NUM_DIGITS-1]};
      SEG <= blank_sel ? 7'b1111111 : seg_decode(digit_sel);
    end
  end

endmodule

// File: doc/seg_timer_scan.md
Name: seg_timer_scan

Overview:
- Parametrised successor to the game's ripple-clocked 00:00 timer.
- Fully synchronous mm:ss-style BCD up/down timer with run/pause/clear/preload and an expiry flag.
- Drives the shared multiplexed 7-segment display through one-hot active-low digit strobes.
- Sits beside the game core; the core drives run/clear and reads `expired` for time-limited rounds.

Parameters:
- CLK_HZ, 50000000, input clock frequency; one count step every CLK_HZ cycles. Minimum 2.
- SCAN_DIV, 2500, CLK cycles per digit-strobe step. Minimum 1.
- NUM_DIGITS, 4, number of displayed digits. Even, 2..8.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- run  in  1  level; 1 = counting, 0 = paused.
- clear  in  1  single-cycle pulse; zero all digits and return to IDLE.
- mode_down  in  1  0 = count up, 1 = count down. Sampled only in IDLE.
- load  in  1  single-cycle pulse; preload digits from load_val. Honoured only in IDLE.
- load_val  in  4*NUM_DIGITS  BCD preload value; digit 0 is in the LSBs.
- SEG  out  7  segments {a,b,c,d,e,f,g}, active-low. "0" = 7'b0000001.
- COM  out  NUM_DIGITS  digit strobes, one-hot, active-low.
- bcd  out  4*NUM_DIGITS  current count.
- running  out  1  high in RUN.
- expired  out  1  level; high in EXPIRED.
- wrap  out  1  one-cycle pulse on count-up rollover.

Behaviour:
- Interface: one clock (CLK); reset RST is synchronous and active-high. No derived clocks; all state is clocked on CLK, and prescalers produce one-cycle enables.
- Reset values:
  - bcd = 0.
  - COM = all ones except bit 0 low.
  - SEG = 7'b0000001.
  - running, expired, wrap = 0.
  - FSM = IDLE; prescalers = 0; latched direction = up.
- Digit moduli: even index counts mod 10, odd index counts mod 6 (ss, mm, hh pairs). load_val digits beyond their modulus are clamped to modulus-1.
- FSM states: IDLE, RUN, PAUSE, EXPIRED.
  - IDLE → RUN when run=1. On entry, latch mode_down and zero the second prescaler, so the first step comes exactly CLK_HZ cycles later.
  - RUN → PAUSE when run=0. The prescaler holds its value, so a paused fraction of a second is retained.
  - PAUSE → RUN when run=1.
  - RUN → EXPIRED in count-down mode, on the step that makes all digits 0.
  - IDLE, RUN, PAUSE or EXPIRED → IDLE on clear.
  - EXPIRED holds bcd = 0 and ignores run until clear.
  - A down-count started from all-zero enters EXPIRED on the first step, with bcd staying 0.
- Priority: RST > clear > load > step. clear on the same cycle as a step: the step is discarded.
- Step, up: ripple carry from digit 0 upward. When all digits are at max they go to 0, wrap pulses for one cycle, and the state stays RUN.
- Step, down: ripple borrow; a digit at 0 becomes modulus-1.
- Latency: bcd changes the cycle after the prescaler terminal count.
- Scan:
  - Every SCAN_DIV cycles the digit index advances 0..NUM_DIGITS-1 and wraps to 0.
  - COM rotates left one position, low bit = active digit.
  - SEG is registered and aligned with COM in the same cycle, from a combinational decode of the selected digit's bcd.
  - Scan runs in every state, including IDLE.
- Decode (active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; other codes = 1111111.

Optional Feature:
- Macro: SEG_TIMER_LEADING_BLANK_EN.
- When defined: any digit above index 1 that is 0 and has only zero digits above it shows SEG = 7'b1111111. Digits 0 and 1 always show. Example: 00:05 on 4 digits displays "  05".
- When undefined: all digits always show their value.

Test Plan:
- CLK_HZ=10, SCAN_DIV=3, NUM_DIGITS=4. Reset, run=1 for 600 cycles → bcd=16'h0100 (01:00); seconds roll 9→0 and 5→0 correctly; running=1.
- load_val=16'h5959 in IDLE, run=1, one step (10 cycles) → bcd=0 and wrap high for exactly 1 cycle.
- mode_down=1, load 16'h0002, run=1 → after 10 cycles bcd=0001; after 20 cycles bcd=0 and expired=1; further run keeps bcd=0 until clear.
- run=1 for 5 cycles, run=0 for 50 cycles, run=1 → next step occurs 5 cycles after resume (prescaler retained).
- clear on the same cycle as a step → bcd=0, FSM IDLE, no wrap; load while in RUN is ignored.
- Scan: idle after reset → COM sequence 1110, 1101, 1011, 0111, 1110, changing every 3 cycles, with SEG=0000001. With SEG_TIMER_LEADING_BLANK_EN and bcd=16'h0005, digits 3 and 2 show 1111111.
